// File: rtl/processor_status_register_if.sv
// processor_status_register_if
// Groups the ALU, data bus and control-unit signals of the 6502 status
// register. The controlling side uses "master"; the status register uses "slave".
interface processor_status_register_if;
  logic [7:0] alu_flags_in;
  logic [7:0] load_mask;
  logic       bus_load;
  logic [7:0] bus_in;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic       irq_entry;
  logic       push_brk;
  logic       instr_done;
  logic       save;
  logic       restore;
  logic [7:0] status_out;
  logic [7:0] push_out;
  logic       irq_mask_eff;
  logic       shadow_empty;
  logic       shadow_full;
  logic       shadow_err;

  modport master (
    output alu_flags_in, load_mask, bus_load, bus_in, set_mask, clr_mask,
           irq_entry, push_brk, instr_done, save, restore,
    input  status_out, push_out, irq_mask_eff, shadow_empty, shadow_full,
           shadow_err
  );

  modport slave (
    input  alu_flags_in, load_mask, bus_load, bus_in, set_mask, clr_mask,
           irq_entry, push_brk, instr_done, save, restore,
    output status_out, push_out, irq_mask_eff, shadow_empty, shadow_full,
           shadow_err
  );
endinterface

// File: rtl/processor_status_register.sv
// processor_status_register
// Full 8-bit 6502 status word (N V - B D I Z C). It supports per-flag ALU
// loads, PLP bus loads, set/clear, and interrupt entry. It also provides an
// instruction-boundary-delayed IRQ mask.
// Optional hardware shadow stack: define STATUS_SHADOW_STACK_EN to build it.
// When the macro is undefined, save/restore are ignored and the shadow
// status outputs are constant.
module processor_status_register #(
  parameter int SHADOW_DEPTH = 4,
  parameter bit RESET_I      = 1'b1
) (
  input logic                         clk,
  input logic                         reset,
  processor_status_register_if.slave  bus
);

  // Only the six real flags are stored, packed as {N,V,D,I,Z,C}.
  logic [5:0] flagsQ;
  logic [5:0] flagsD;
  logic       irqMaskQ;
  logic [7:0] curP;
  logic [7:0] nextP;
  logic       popValid;
  logic [5:0] popFlags;
  logic       unusedP;

  assign curP    = {flagsQ[5:4], 2'b11, flagsQ[3:0]};
  assign flagsD  = {nextP[7:6], nextP[3:0]};
  assign unusedP = ^nextP[5:4];

  // Apply the flag sources from lowest to highest priority so that later ones win.
  always_comb begin
    nextP = curP;
    nextP = (nextP & ~bus.load_mask) | (bus.alu_flags_in & bus.load_mask);
    nextP = nextP | bus.set_mask;
    nextP = nextP & ~bus.clr_mask;
    if (bus.bus_load) nextP = bus.bus_in;
    if (popValid)     nextP = {popFlags[5:4], 2'b11, popFlags[3:0]};
    if (bus.irq_entry) nextP[2] = 1'b1;
  end

  // Flag storage, plus an IRQ mask that samples the old I flag at instruction boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flagsQ   <= {3'b000, RESET_I, 2'b00};
      irqMaskQ <= RESET_I;
    end else begin
      flagsQ <= flagsD;
      if (bus.instr_done) irqMaskQ <= flagsQ[2];
    end
  end

`ifdef STATUS_SHADOW_STACK_EN
  localparam int CW = $clog2(SHADOW_DEPTH + 1);
  localparam int IW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

  logic [CW-1:0] countQ;
  logic [CW-1:0] countD;
  logic          emptyQ;
  logic          fullQ;
  logic          errQ;
  logic [5:0]    stackQ [SHADOW_DEPTH];
  logic          pushValid;
  logic          errEvent;

  // Classify the save/restore request. A simultaneous save and restore is
  // rejected as a whole.
  always_comb begin
    pushValid = bus.save & ~bus.restore & (countQ < CW'(SHADOW_DEPTH));
    popValid  = bus.restore & ~bus.save & (countQ != '0);
    errEvent  = (bus.save & bus.restore)
              | (bus.save & ~bus.restore & (countQ == CW'(SHADOW_DEPTH)))
              | (bus.restore & ~bus.save & (countQ == '0));
    popFlags  = stackQ[IW'(countQ - CW'(1))];
    countD    = countQ;
    if (pushValid)     countD = countQ + CW'(1);
    else if (popValid) countD = countQ - CW'(1);
  end

  // Stack pointer, registered full/empty, and a sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countQ <= '0;
      emptyQ <= 1'b1;
      fullQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      countQ <= countD;
      emptyQ <= (countD == '0);
      fullQ  <= (countD == CW'(SHADOW_DEPTH));
      if (errEvent) errQ <= 1'b1;
    end
  end

  // Stack storage holds the flags as they were before this cycle's update; it needs no reset.
  always_ff @(posedge clk) begin
    if (pushValid) stackQ[IW'(countQ)] <= flagsQ;
  end

  assign bus.shadow_empty = emptyQ;
  assign bus.shadow_full  = fullQ;
  assign bus.shadow_err   = errQ;
`else
  logic unusedShadow;

  assign popValid         = 1'b0;
  assign popFlags         = '0;
  assign unusedShadow     = bus.save ^ bus.restore;
  assign bus.shadow_empty = 1'b1;
  assign bus.shadow_full  = 1'b0;
  assign bus.shadow_err   = 1'b0;
`endif

  assign bus.status_out   = curP;
  assign bus.push_out     = {curP[7:5], bus.push_brk, curP[3:0]};
  assign bus.irq_mask_eff = irqMaskQ;

endmodule

// File: tb/tb_processor_status_register.sv
// tb_processor_status_register
// Scoreboard bench for processor_status_register (SHADOW_DEPTH=2, RESET_I=1).
// Shadow-stack scenarios follow STATUS_SHADOW_STACK_EN.
module tb_processor_status_register;

  typedef struct packed {
    logic [7:0] alu;
    logic [7:0] loadMask;
    logic       busLoad;
    logic [7:0] busIn;
    logic [7:0] setMask;
    logic [7:0] clrMask;
    logic       irqEntry;
    logic       pushBrk;
    logic       instrDone;
    logic       save;
    logic       restore;
  } stim_t;

  typedef struct {
    string       name;
    logic [19:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stim_t stimQ[$];
  exp_t  expQ[$];

  processor_status_register_if psrIf ();

  processor_status_register #(
    .SHADOW_DEPTH (2),
    .RESET_I      (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (psrIf.slave)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs, packed as {status, push, irq_mask_eff, empty, full, err}.
  function automatic logic [19:0] observe();
    return {psrIf.status_out, psrIf.push_out, psrIf.irq_mask_eff,
            psrIf.shadow_empty, psrIf.shadow_full, psrIf.shadow_err};
  endfunction

  task automatic driveIdle();
    psrIf.alu_flags_in = '0;
    psrIf.load_mask    = '0;
    psrIf.bus_load     = 1'b0;
    psrIf.bus_in       = '0;
    psrIf.set_mask     = '0;
    psrIf.clr_mask     = '0;
    psrIf.irq_entry    = 1'b0;
    psrIf.push_brk     = 1'b0;
    psrIf.instr_done   = 1'b0;
    psrIf.save         = 1'b0;
    psrIf.restore      = 1'b0;
  endtask

  // Drive one cycle of stimulus, let the edge happen, then return inputs to idle.
  // Push_brk is deliberately left driven so its combinational effect can be observed.
  task automatic applyStimulus(input stim_t s);
    psrIf.alu_flags_in = s.alu;
    psrIf.load_mask    = s.loadMask;
    psrIf.bus_load     = s.busLoad;
    psrIf.bus_in       = s.busIn;
    psrIf.set_mask     = s.setMask;
    psrIf.clr_mask     = s.clrMask;
    psrIf.irq_entry    = s.irqEntry;
    psrIf.push_brk     = s.pushBrk;
    psrIf.instr_done   = s.instrDone;
    psrIf.save         = s.save;
    psrIf.restore      = s.restore;
    @(posedge clk);
    #1;
    psrIf.alu_flags_in = '0;
    psrIf.load_mask    = '0;
    psrIf.bus_load     = 1'b0;
    psrIf.bus_in       = '0;
    psrIf.set_mask     = '0;
    psrIf.clr_mask     = '0;
    psrIf.irq_entry    = 1'b0;
    psrIf.instr_done   = 1'b0;
    psrIf.save         = 1'b0;
    psrIf.restore      = 1'b0;
  endtask

  // Queue a stimulus together with its expected outcome.
  task automatic queueStep(input stim_t s, input string name, input logic [7:0] st,
                           input logic [7:0] pu, input logic irq, input logic emp,
                           input logic full, input logic err);
    exp_t e;
    e.name = name;
    e.val  = {st, pu, irq, emp, full, err};
    stimQ.push_back(s);
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    e.name = "reset_state";
    e.val  = {8'h34, 8'h24, 1'b1, 1'b1, 1'b0, 1'b0};
    expQ.push_back(e);
    e = expQ.pop_front();
    checks++;
    if (observe() !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
    end
  endtask

  task automatic test_flags();
    stim_t s;
    exp_t  e;
    s = '0; s.loadMask = 8'h83; s.alu = 8'hFF;
    queueStep(s, "alu_load_83", 8'hB7, 8'hA7, 1, 1, 0, 0);
    s = '0; s.loadMask = 8'h42; s.alu = 8'h40;
    queueStep(s, "alu_load_42", 8'hF5, 8'hE5, 1, 1, 0, 0);
    s = '0; s.setMask = 8'h01; s.clrMask = 8'h01; s.loadMask = 8'h01; s.alu = 8'h01;
    queueStep(s, "clr_beats_set", 8'hF4, 8'hE4, 1, 1, 0, 0);
    s = '0; s.setMask = 8'h09; s.loadMask = 8'h01; s.alu = 8'h00;
    queueStep(s, "set_beats_load", 8'hFD, 8'hED, 1, 1, 0, 0);
    s = '0; s.clrMask = 8'h48;
    queueStep(s, "clv_cld", 8'hB5, 8'hA5, 1, 1, 0, 0);
    while (stimQ.size() > 0) begin
      applyStimulus(stimQ.pop_front());
      e = expQ.pop_front();
      checks++;
      if (observe() !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
      end
    end
  endtask

  task automatic test_irq_mask();
    stim_t s;
    exp_t  e;
    s = '0; s.clrMask = 8'h04;
    queueStep(s, "cli_no_boundary", 8'hB1, 8'hA1, 1, 1, 0, 0);
    s = '0; s.instrDone = 1'b1;
    queueStep(s, "cli_after_boundary", 8'hB1, 8'hA1, 0, 1, 0, 0);
    s = '0; s.irqEntry = 1'b1; s.clrMask = 8'h04; s.instrDone = 1'b1;
    queueStep(s, "irq_entry_overrides", 8'hB5, 8'hA5, 0, 1, 0, 0);
    s = '0; s.instrDone = 1'b1;
    queueStep(s, "mask_follows_entry", 8'hB5, 8'hA5, 1, 1, 0, 0);
    while (stimQ.size() > 0) begin
      applyStimulus(stimQ.pop_front());
      e = expQ.pop_front();
      checks++;
      if (observe() !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
      end
    end
  endtask

  task automatic test_bus_load();
    stim_t s;
    exp_t  e;
    s = '0; s.busLoad = 1'b1; s.busIn = 8'hCF; s.setMask = 8'h01; s.clrMask = 8'h80;
    queueStep(s, "plp_cf", 8'hFF, 8'hEF, 1, 1, 0, 0);
    s = '0; s.busLoad = 1'b1; s.busIn = 8'h00; s.pushBrk = 1'b1;
    queueStep(s, "plp_00_brk", 8'h30, 8'h30, 1, 1, 0, 0);
    while (stimQ.size() > 0) begin
      applyStimulus(stimQ.pop_front());
      e = expQ.pop_front();
      checks++;
      if (observe() !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
      end
    end
    psrIf.push_brk = 1'b0;
  endtask

`ifdef STATUS_SHADOW_STACK_EN
  task automatic test_shadow_stack();
    stim_t s;
    exp_t  e;
    s = '0; s.setMask = 8'h05;
    queueStep(s, "prep_35", 8'h35, 8'h25, 1, 1, 0, 0);
    s = '0; s.save = 1'b1; s.busLoad = 1'b1; s.busIn = 8'hF4;
    queueStep(s, "save_35_load_f4", 8'hF4, 8'hE4, 1, 0, 0, 0);
    s = '0; s.save = 1'b1;
    queueStep(s, "save_f4_full", 8'hF4, 8'hE4, 1, 0, 1, 0);
    s = '0; s.save = 1'b1; s.setMask = 8'h01;
    queueStep(s, "save_overflow", 8'hF5, 8'hE5, 1, 0, 1, 1);
    s = '0; s.restore = 1'b1; s.busLoad = 1'b1; s.busIn = 8'h00;
    queueStep(s, "restore_f4", 8'hF4, 8'hE4, 1, 0, 0, 1);
    s = '0; s.restore = 1'b1;
    queueStep(s, "restore_35", 8'h35, 8'h25, 1, 1, 0, 1);
    s = '0; s.restore = 1'b1;
    queueStep(s, "restore_underflow", 8'h35, 8'h25, 1, 1, 0, 1);
    s = '0; s.restore = 1'b1; s.setMask = 8'h40;
    queueStep(s, "underflow_lower_src", 8'h75, 8'h65, 1, 1, 0, 1);
    s = '0; s.save = 1'b1; s.restore = 1'b1; s.clrMask = 8'h01;
    queueStep(s, "save_restore_conflict", 8'h74, 8'h64, 1, 1, 0, 1);
    while (stimQ.size() > 0) begin
      applyStimulus(stimQ.pop_front());
      e = expQ.pop_front();
      checks++;
      if (observe() !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
      end
    end
  endtask
`else
  task automatic test_shadow_disabled();
    stim_t s;
    exp_t  e;
    s = '0; s.save = 1'b1; s.setMask = 8'h05;
    queueStep(s, "nostack_save", 8'h35, 8'h25, 1, 1, 0, 0);
    s = '0; s.restore = 1'b1; s.busLoad = 1'b1; s.busIn = 8'hF4;
    queueStep(s, "nostack_restore", 8'hF4, 8'hE4, 1, 1, 0, 0);
    s = '0; s.save = 1'b1; s.restore = 1'b1;
    queueStep(s, "nostack_conflict", 8'hF4, 8'hE4, 1, 1, 0, 0);
    s = '0; s.restore = 1'b1;
    queueStep(s, "nostack_underflow", 8'hF4, 8'hE4, 1, 1, 0, 0);
    while (stimQ.size() > 0) begin
      applyStimulus(stimQ.pop_front());
      e = expQ.pop_front();
      checks++;
      if (observe() !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
      end
    end
  endtask
`endif

  task automatic test_reset_midop();
    exp_t e;
    psrIf.save     = 1'b1;
    psrIf.set_mask = 8'hC1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    e.name = "async_reset";
    e.val  = {8'h34, 8'h24, 1'b1, 1'b1, 1'b0, 1'b0};
    expQ.push_back(e);
    e = expQ.pop_front();
    checks++;
    if (observe() !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
    end
    driveIdle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    e.name = "after_reset_release";
    e.val  = {8'h34, 8'h24, 1'b1, 1'b1, 1'b0, 1'b0};
    expQ.push_back(e);
    e = expQ.pop_front();
    checks++;
    if (observe() !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, observe(), e.val);
    end
  endtask

  // Main sequence: reset, then each scenario in turn, then the summary.
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    driveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("[TB] starting scenarios");
    test_reset();
    test_flags();
    test_irq_mask();
    test_bus_load();
`ifdef STATUS_SHADOW_STACK_EN
    test_shadow_stack();
`else
    test_shadow_disabled();
`endif
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor_status_register.md
# processor_status_register

Parametrised successor to the four-flag status register: holds the full 8-bit 6502 processor status word (N V - B D I Z C) with per-flag ALU load masks, bus load (PLP), explicit set/clear (SEC/CLC/SEI/CLI/SED/CLD/CLV), and interrupt entry. It also provides an instruction-boundary-delayed interrupt mask and an optional hardware shadow stack for interrupt save/restore. It sits between the ALU, the data bus and the control unit.

## Interface
- `SHADOW_DEPTH`, 4: number of shadow stack entries, from 1 to 16.
- `RESET_I`, 1: reset value of the I flag and of `irq_mask_eff`.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `alu_flags_in` input 8: candidate flags in P bit order (0 C, 1 Z, 2 I, 3 D, 6 V, 7 N); bits 4 and 5 are ignored.
- `load_mask` input 8: per-bit load enable for `alu_flags_in`.
- `bus_load` input 1: load the whole word from `bus_in` (PLP).
- `bus_in` input 8: data bus value; bits 4 and 5 are ignored.
- `set_mask` input 8: one-hot or multi-bit flag set.
- `clr_mask` input 8: flag clear.
- `irq_entry` input 1: interrupt/BRK entry; forces I=1.
- `push_brk` input 1: value of bit 4 in `push_out`.
- `instr_done` input 1: instruction boundary strobe.
- `save` input 1: push the current status onto the shadow stack.
- `restore` input 1: pop the shadow stack into the status.
- `status_out` output 8: current status; bits 5 and 4 always read 1.
- `push_out` output 8: `status_out` with bit 4 = `push_brk`. Combinational.
- `irq_mask_eff` output 1: I flag as sampled at the last instruction boundary.
- `shadow_empty` output 1: shadow stack is empty.
- `shadow_full` output 1: shadow stack is full.
- `shadow_err` output 1: sticky; set by overflow, underflow or a save/restore conflict.

## Operation
- Storage: six flag flops (C Z I D V N). Bits 4 and 5 are constants, not stored.
- Per-flag next-value priority, highest first:
  1. `restore` (valid pop)
  2. `bus_load`
  3. `clr_mask` bit
  4. `set_mask` bit
  5. `load_mask` bit (takes `alu_flags_in`)
  6. hold
- `irq_entry` overrides every source for I only. It sets I=1 regardless of other inputs.
- Setting and clearing the same bit in one cycle: the clear wins.
- `irq_mask_eff`: updated only when `instr_done`=1, taking the I value before that cycle's update. CLI/SEI/PLP therefore affect IRQ recognition one instruction late.
- Shadow stack: LIFO, `SHADOW_DEPTH` × 6 bits, with a pointer `count` from 0 to `SHADOW_DEPTH`.
  - `save` with `count` < depth: writes the pre-update flags, `count`+1.
  - `save` when full: dropped, `shadow_err` set.
  - `restore` with `count` > 0: status takes the top entry, `count`-1.
  - `restore` when empty: status follows the normal lower priorities; `shadow_err` set.
  - `save` and `restore` together: both ignored, `shadow_err` set; lower-priority flag sources still apply.
- `shadow_err` clears only on reset.

## Timing
- All flag updates are visible on `status_out` the cycle after the controlling input is sampled high.
- `push_out` follows `status_out` and `push_brk` combinationally, with zero latency.
- `shadow_full` and `shadow_empty` are registered and track `count` one cycle after the `save`/`restore` edge.
- Reset (asynchronous assert, clocked release) produces:
  - C, Z, D, V, N = 0; I = `RESET_I`.
  - `status_out` = 0x34 when `RESET_I`=1, 0x30 when `RESET_I`=0.
  - `irq_mask_eff` = `RESET_I`.
  - `count` = 0, `shadow_empty` = 1, `shadow_full` = 0, `shadow_err` = 0.
- Reset asserted mid-operation aborts any save or restore; stack contents are don't-care.

## Configuration
- `STATUS_SHADOW_STACK_EN` defined: the shadow stack is built as described above.
- `STATUS_SHADOW_STACK_EN` undefined: no stack storage is built.
  - `save` and `restore` are ignored.
  - `shadow_empty` = 1, `shadow_full` = 0, `shadow_err` = 0, all constant.
  - All other behaviour is unchanged.

## Test plan
- Reset, `RESET_I`=1 → `status_out`=0x34, `irq_mask_eff`=1, `shadow_empty`=1.
- `load_mask`=0x83 with `alu_flags_in`=0xFF → next cycle `status_out`=0xB7; V and D unchanged.
- `set_mask`=0x01 with `clr_mask`=0x01 and `load_mask`=0x01 with `alu_flags_in` bit 0 = 1 → C=0.
- CLI (`clr_mask`=0x04) without `instr_done` → I=0 but `irq_mask_eff` stays 1. After one `instr_done` → `irq_mask_eff`=0.
- `bus_in`=0xCF with `bus_load` and `push_brk`=0 → `status_out`=0xFF, `push_out`=0xEF.
- `SHADOW_DEPTH`=2, macro defined:
  - Save status 0x35, then save 0xF4 → `shadow_full`=1.
  - A third save → `shadow_err`=1, stack unchanged.
  - Two restores → 0xF4 then 0x35, `shadow_empty`=1.
  - A further restore → status held, `shadow_err` stays 1.
